// File: rtl/br_rs.sv
// Branch/jump reservation station: age-ordered collapsing queue with CDB wakeup
// and oldest-ready select. Optional macro BR_RS_BYPASS_EN adds same-cycle CDB bypass into select.
package br_rs_pkg;
    localparam int ROB_IDX_W = 5;

    localparam logic [1:0] OP_BRANCH = 2'd0;
    localparam logic [1:0] OP_JAL    = 2'd1;
    localparam logic [1:0] OP_JALR   = 2'd2;

    typedef struct packed {
        logic                 valid;
        logic [1:0]           op;
        logic [2:0]           funct3;
        logic [31:0]          pc;
        logic [31:0]          imm;
        logic [ROB_IDX_W-1:0] rob_idx;
        logic                 rs1_ready;
        logic [ROB_IDX_W-1:0] rs1_rob_idx;
        logic [31:0]          rs1_data;
        logic                 rs2_ready;
        logic [ROB_IDX_W-1:0] rs2_rob_idx;
        logic [31:0]          rs2_data;
    } reservation_station_t;
endpackage

module br_rs
    import br_rs_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int ROB_IDX_W = br_rs_pkg::ROB_IDX_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         dispatch_valid,
    input  reservation_station_t         dispatch_entry,
    output logic                         dispatch_ready,
    input  logic                         cdb_valid,
    input  logic [ROB_IDX_W-1:0]         cdb_rob_idx,
    input  logic [31:0]                  cdb_data,
    input  logic                         exec_ready,
    output reservation_station_t         next_execute,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = br_rs_pkg::ROB_IDX_W;

    function automatic reservation_station_t wake(input reservation_station_t e,
                                                  input logic v,
                                                  input logic [PW-1:0] tag,
                                                  input logic [31:0] data);
        wake = e;
        if (e.valid && v) begin
            if (!e.rs1_ready && e.rs1_rob_idx == tag) begin
                wake.rs1_ready = 1'b1;
                wake.rs1_data  = data;
            end
            if (!e.rs2_ready && e.rs2_rob_idx == tag) begin
                wake.rs2_ready = 1'b1;
                wake.rs2_data  = data;
            end
        end
    endfunction

    // JAL needs no register operands; JALR only needs rs1.
    function automatic logic is_ready(input reservation_station_t e);
        is_ready = e.valid && ((e.op == OP_JAL) ||
                               (e.rs1_ready && ((e.op == OP_JALR) || e.rs2_ready)));
    endfunction

    reservation_station_t entries_q [DEPTH];
    reservation_station_t entries_d [DEPTH];
    reservation_station_t woken     [DEPTH];
    reservation_station_t cand      [DEPTH];
    reservation_station_t shifted   [DEPTH];
    reservation_station_t disp_woken;
    logic [DEPTH-1:0]     rdy;
    logic [CW-1:0]        count_q, count_d, wr_idx;
    logic [IW-1:0]        sel_idx;
    logic                 sel_found, issue, accept;
    logic [PW-1:0]        cdb_tag;

    assign cdb_tag = PW'(cdb_rob_idx);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            assign woken[gi] = wake(entries_q[gi], cdb_valid, cdb_tag, cdb_data);
`ifdef BR_RS_BYPASS_EN
            assign cand[gi] = woken[gi];
`else
            assign cand[gi] = entries_q[gi];
`endif
            assign rdy[gi] = is_ready(cand[gi]);
            if (gi < DEPTH-1) begin : g_up
                assign shifted[gi] = woken[gi+1];
            end else begin : g_top
                assign shifted[gi] = '0;
            end
        end
    endgenerate

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (rdy[i]) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
        end
    end

    assign dispatch_ready = (count_q != CW'(DEPTH));
    assign issue          = sel_found && exec_ready;
    assign accept         = dispatch_valid && dispatch_ready && !flush;
    assign wr_idx         = count_q - CW'(issue);
    assign next_execute   = sel_found ? cand[sel_idx] : '0;
    assign count          = count_q;

    always_comb begin
        reservation_station_t de;
        de         = dispatch_entry;
        de.valid   = 1'b1;
        disp_woken = wake(de, cdb_valid, cdb_tag, cdb_data);
        for (int i = 0; i < DEPTH; i++) begin
            entries_d[i] = (issue && (i >= int'(sel_idx))) ? shifted[i] : woken[i];
            if (accept && (CW'(i) == wr_idx)) begin
                entries_d[i] = disp_woken;
            end
            if (flush) begin
                entries_d[i] = '0;
            end
        end
        count_d = flush ? '0 : (wr_idx + CW'(accept));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_br_rs.sv
// Directed testbench for br_rs: ordering, wakeup, full stall, hold and flush.
module tb_br_rs;
    import br_rs_pkg::*;

`ifdef BR_RS_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst, flush, dispatch_valid, dispatch_ready;
    reservation_station_t dispatch_entry, next_execute;
    logic                 cdb_valid, exec_ready;
    logic [4:0]           cdb_rob_idx;
    logic [31:0]          cdb_data;
    logic [2:0]           count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    br_rs #(.DEPTH(4), .ROB_IDX_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .dispatch_valid(dispatch_valid), .dispatch_entry(dispatch_entry),
        .dispatch_ready(dispatch_ready),
        .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx), .cdb_data(cdb_data),
        .exec_ready(exec_ready), .next_execute(next_execute), .count(count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic reservation_station_t mk(input logic [1:0] op, input logic [31:0] pc,
                                                input logic r1, input logic [4:0] t1, input logic [31:0] d1,
                                                input logic r2, input logic [4:0] t2, input logic [31:0] d2);
        reservation_station_t e;
        e             = '0;
        e.valid       = 1'b1;
        e.op          = op;
        e.pc          = pc;
        e.rs1_ready   = r1;
        e.rs1_rob_idx = t1;
        e.rs1_data    = d1;
        e.rs2_ready   = r2;
        e.rs2_rob_idx = t2;
        e.rs2_data    = d2;
        return e;
    endfunction

    task automatic cdb(input logic v, input logic [4:0] t, input logic [31:0] d);
        cdb_valid   = v;
        cdb_rob_idx = t;
        cdb_data    = d;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; dispatch_valid = 1'b0; dispatch_entry = '0;
        exec_ready = 1'b1;
        cdb(1'b0, 5'd0, 32'd0);
        tick(); tick();
        rst = 1'b0;
        #2;
        check("rst_count", 32'(count), 0);
        check("rst_dready", 32'(dispatch_ready), 1);
        check("rst_valid", 32'(next_execute.valid), 0);

        // BEQ with both operands ready
        dispatch_valid = 1'b1;
        dispatch_entry = mk(OP_BRANCH, 32'h100, 1'b1, 5'd0, 32'd5, 1'b1, 5'd0, 32'd5);
        #2 check("beq_pre_valid", 32'(next_execute.valid), 0);
        tick(); dispatch_valid = 1'b0;
        #2;
        check("beq_count1", 32'(count), 1);
        check("beq_valid", 32'(next_execute.valid), 1);
        check("beq_pc", next_execute.pc, 32'h100);
        check("beq_rs1", next_execute.rs1_data, 5);
        check("beq_rs2", next_execute.rs2_data, 5);
        tick(); #2;
        check("beq_count0", 32'(count), 0);
        check("beq_post_valid", 32'(next_execute.valid), 0);

        // JAL issues even though its operand flags are not ready
        dispatch_valid = 1'b1;
        dispatch_entry = mk(OP_JAL, 32'h180, 1'b0, 5'd9, 32'd0, 1'b0, 5'd9, 32'd0);
        tick(); dispatch_valid = 1'b0;
        #2;
        check("jal_valid", 32'(next_execute.valid), 1);
        check("jal_pc", next_execute.pc, 32'h180);
        tick(); #2;
        check("jal_count0", 32'(count), 0);

        // BNE waiting on tag 3, broadcast two cycles later
        dispatch_valid = 1'b1;
        dispatch_entry = mk(OP_BRANCH, 32'h200, 1'b0, 5'd3, 32'd0, 1'b1, 5'd0, 32'd7);
        tick(); dispatch_valid = 1'b0;
        #2;
        check("bne_count1", 32'(count), 1);
        check("bne_wait_valid", 32'(next_execute.valid), 0);
        tick(); #2;
        check("bne_wait2_valid", 32'(next_execute.valid), 0);
        cdb(1'b1, 5'd3, 32'h10);
        #2;
        check("bne_cdb_valid", 32'(next_execute.valid), BYP ? 1 : 0);
        check("bne_cdb_rs1", next_execute.rs1_data, BYP ? 32'h10 : 32'h0);
        tick(); cdb(1'b0, 5'd0, 32'd0);
        #2;
        check("bne_after_valid", 32'(next_execute.valid), BYP ? 0 : 1);
        check("bne_after_rs1", next_execute.rs1_data, BYP ? 32'h0 : 32'h10);
        check("bne_after_count", 32'(count), BYP ? 0 : 1);
        tick(); #2;
        check("bne_count0", 32'(count), 0);

        // Younger ready op B overtakes older waiting op A
        dispatch_valid = 1'b1;
        dispatch_entry = mk(OP_BRANCH, 32'h300, 1'b0, 5'd1, 32'd0, 1'b1, 5'd0, 32'd0);
        tick();
        dispatch_entry = mk(OP_BRANCH, 32'h310, 1'b1, 5'd0, 32'hA, 1'b1, 5'd0, 32'hA);
        tick(); dispatch_valid = 1'b0;
        #2;
        check("ooo_count2", 32'(count), 2);
        check("ooo_b_pc", next_execute.pc, 32'h310);
        tick(); #2;
        check("ooo_count1", 32'(count), 1);
        check("ooo_a_wait", 32'(next_execute.valid), 0);
        cdb(1'b1, 5'd1, 32'h55);
        exec_ready = 1'b0;
        tick(); cdb(1'b0, 5'd0, 32'd0); exec_ready = 1'b1;
        #2;
        check("ooo_a_pc", next_execute.pc, 32'h300);
        check("ooo_a_rs1", next_execute.rs1_data, 32'h55);
        check("ooo_a_count", 32'(count), 1);
        tick(); #2;
        check("ooo_count0", 32'(count), 0);

        // Fill with ops waiting on tag 7; full stalls dispatch even across an issue
        for (int k = 0; k < 4; k++) begin
            dispatch_valid = 1'b1;
            dispatch_entry = mk(OP_BRANCH, 32'h400 + 32'(4*k), 1'b0, 5'd7, 32'd0, 1'b1, 5'd0, 32'(k));
            tick();
        end
        dispatch_entry = mk(OP_BRANCH, 32'h4F0, 1'b1, 5'd0, 32'd0, 1'b1, 5'd0, 32'd0);
        cdb(1'b1, 5'd7, 32'h77);
        exec_ready = 1'b0;
        #2;
        check("full_count", 32'(count), 4);
        check("full_dready", 32'(dispatch_ready), 0);
        tick(); cdb(1'b0, 5'd0, 32'd0); exec_ready = 1'b1;
        #2;
        check("full_issue_dready", 32'(dispatch_ready), 0);
        check("full_pc0", next_execute.pc, 32'h400);
        check("full_rs1", next_execute.rs1_data, 32'h77);
        tick(); #2;
        check("full_dready_back", 32'(dispatch_ready), 1);
        check("full_count3", 32'(count), 3);
        check("full_pc1", next_execute.pc, 32'h404);
        dispatch_valid = 1'b0;
        tick(); #2;
        check("full_pc2", next_execute.pc, 32'h408);
        check("full_count2", 32'(count), 2);
        tick(); #2;
        check("full_pc3", next_execute.pc, 32'h40C);
        check("full_count1", 32'(count), 1);
        tick(); #2;
        check("full_count0", 32'(count), 0);
        check("full_empty_valid", 32'(next_execute.valid), 0);

        // Back-pressure: slot-0 op held while exec_ready is low
        exec_ready = 1'b0;
        dispatch_valid = 1'b1;
        dispatch_entry = mk(OP_BRANCH, 32'h500, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0, 32'd1);
        tick();
        dispatch_entry = mk(OP_JALR, 32'h504, 1'b1, 5'd0, 32'd2, 1'b0, 5'd4, 32'd0);
        tick(); dispatch_valid = 1'b0;
        for (int r = 0; r < 3; r++) begin
            #2;
            check($sformatf("hold%0d_pc", r), next_execute.pc, 32'h500);
            check($sformatf("hold%0d_count", r), 32'(count), 2);
            tick();
        end
        exec_ready = 1'b1;
        #2 check("hold_rel_pc", next_execute.pc, 32'h500);
        tick(); #2;
        check("hold_jalr_pc", next_execute.pc, 32'h504);
        check("hold_jalr_count", 32'(count), 1);
        tick(); #2;
        check("hold_count0", 32'(count), 0);

        // Dispatch during an issue, woken by a broadcast in its accept cycle
        exec_ready = 1'b0;
        dispatch_valid = 1'b1;
        dispatch_entry = mk(OP_BRANCH, 32'h600, 1'b1, 5'd0, 32'd0, 1'b1, 5'd0, 32'd0);
        tick();
        exec_ready = 1'b1;
        dispatch_entry = mk(OP_BRANCH, 32'h610, 1'b0, 5'd12, 32'd0, 1'b1, 5'd0, 32'd0);
        cdb(1'b1, 5'd12, 32'hAB);
        #2 check("ovl_issue_pc", next_execute.pc, 32'h600);
        tick(); dispatch_valid = 1'b0; cdb(1'b0, 5'd0, 32'd0);
        #2;
        check("ovl_count", 32'(count), 1);
        check("ovl_valid", 32'(next_execute.valid), 1);
        check("ovl_pc", next_execute.pc, 32'h610);
        check("ovl_rs1", next_execute.rs1_data, 32'hAB);
        tick(); #2;
        check("ovl_count0", 32'(count), 0);

        // Flush with three entries and a same-cycle dispatch
        for (int k = 0; k < 3; k++) begin
            dispatch_valid = 1'b1;
            dispatch_entry = mk(OP_BRANCH, 32'h700 + 32'(4*k), 1'b0, 5'd30, 32'd0, 1'b1, 5'd0, 32'd0);
            tick();
        end
        dispatch_entry = mk(OP_BRANCH, 32'h7F0, 1'b1, 5'd0, 32'd0, 1'b1, 5'd0, 32'd0);
        flush = 1'b1;
        #2 check("fl_pre_count", 32'(count), 3);
        tick(); flush = 1'b0; dispatch_valid = 1'b0;
        #2;
        check("fl_count", 32'(count), 0);
        check("fl_valid", 32'(next_execute.valid), 0);
        check("fl_dready", 32'(dispatch_ready), 1);
        cdb(1'b1, 5'd30, 32'h30);
        tick(); cdb(1'b0, 5'd0, 32'd0);
        #2;
        check("fl_post_valid", 32'(next_execute.valid), 0);
        check("fl_post_count", 32'(count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/br_rs.md
# br_rs

Branch/jump reservation station: buffers dispatched JAL, JALR and conditional-branch ops until their source operands are available, then issues the oldest ready op to the branch unit. Sits between dispatch/rename and `br_unit`. Operands are captured from dispatch and from CDB broadcasts. The whole station is cleared on a pipeline flush.

## Interface
- `DEPTH`, 4: number of entries, range 2..16.
- `ROB_IDX_W`, 5: width of ROB index tags.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: mispredict/redirect; discard all entries.
- `dispatch_valid` in 1: dispatch presents a branch-class op.
- `dispatch_entry` in `reservation_station_t`: op payload.
  - Includes `rs1_ready`/`rs2_ready`, `rs1_rob_idx`/`rs2_rob_idx`, `rs1_data`/`rs2_data` and `valid`.
- `dispatch_ready` out 1: station can accept this cycle.
- `cdb_valid` in 1: CDB broadcast valid.
- `cdb_rob_idx` in `ROB_IDX_W`: producer tag.
- `cdb_data` in 32: produced value.
- `exec_ready` in 1: branch unit accepts an op this cycle.
- `next_execute` out `reservation_station_t`: issued op to `br_unit`; `.valid` marks issue.
- `count` out `$clog2(DEPTH+1)`: occupied entries.

## Operation
- **Storage:** age-ordered collapsing queue.
  - Slot 0 is the oldest; occupied slots are contiguous from 0.
- **Dispatch:**
  - Accepted when `dispatch_valid && dispatch_ready && !flush`.
  - Written to slot `count` after any same-cycle collapse, i.e. slot `count-1` if an issue also occurs.
  - `dispatch_ready = (count != DEPTH)`. It does not depend on a same-cycle issue, so there is no pass-through when full.
- **Wakeup:**
  - For every occupied entry with `rsN_ready == 0` and `rsN_rob_idx == cdb_rob_idx` under `cdb_valid`: set `rsN_ready` and latch `cdb_data`.
  - A dispatching op is checked against the same broadcast before it is written, so a broadcast in the accept cycle is not lost.
  - An operand already ready is never overwritten.
- **Select:** lowest-index occupied entry with both operands ready.
  - JAL is treated as ready regardless of `rs1_ready`/`rs2_ready`.
  - JALR and JAL ignore `rs2_ready`.
- **Issue:**
  - `next_execute` = selected entry with `.valid = 1`; otherwise all-zero with `.valid = 0`.
  - The entry is removed at the clock edge only if `exec_ready` is high.
  - Entries above it shift down one slot, with any same-cycle wakeup applied to the shifted copy.
- **Flush:**
  - Next edge: all entries invalid, `count = 0`.
  - A same-cycle dispatch is dropped.
  - A same-cycle issue still drives `next_execute` combinationally; the downstream stage discards it via its own flush.
- **Count:** `count_next = count - issued + accepted`; it never exceeds `DEPTH`.

## Timing
- Reset: all entries invalid, `count = 0`, `dispatch_ready = 1`, `next_execute.valid = 0`.
- Issue output is combinational from registered entry state.
- An op dispatched with both operands ready, or completed by the CDB in its dispatch cycle, can issue the cycle after acceptance.
- CDB wakeup to issue latency: 1 cycle (broadcast in cycle N, issue in cycle N+1).
- Issue throughput: 1 op/cycle.
- Full: with `count == DEPTH`, dispatch is stalled even when an issue occurs that cycle; `dispatch_ready` rises the cycle after the issue.
- `rst` has priority over `flush`, and `flush` over dispatch, wakeup and issue removal.

## Configuration
- `BR_RS_BYPASS_EN`:
  - **Defined:** select also treats an operand as ready when `cdb_valid && cdb_rob_idx` matches its pending tag that cycle, and `next_execute` carries `cdb_data` for that operand. CDB-to-issue latency becomes 0 cycles.
  - **Undefined:** latency is 1 cycle as in Timing.
  - Storage, wakeup, dispatch and flush behaviour are identical either way.

## Test plan
- Reset, then dispatch BEQ with both operands ready (`rs1_data = rs2_data = 5`) -> `next_execute.valid = 1` the following cycle with the same data; `count` goes 1 -> 0 after the issue edge.
- Dispatch BNE waiting on tag 3, then CDB `{3, 0x10}` two cycles later -> issue one cycle after the broadcast with `rs1_data = 0x10` (zero cycles with `BR_RS_BYPASS_EN`).
- Dispatch A (waits on tag 1), then B (ready) -> B issues first. After CDB tag 1, A issues and occupies slot 0.
- Fill `DEPTH = 4` with ops waiting on tag 7 -> `dispatch_ready = 0`. Broadcast tag 7 -> entries issue in dispatch order, one per cycle; `dispatch_ready` returns after the first issue edge.
- Two ready entries, `exec_ready = 0` for 3 cycles -> `next_execute` holds the slot-0 op unchanged, `count` stays 2.
- `flush` with 3 entries plus a same-cycle dispatch -> next cycle `count = 0`, `next_execute.valid = 0`, and the dispatched op never issues.
